// File: rtl/deser_queue_top.sv
// Byte collector: MSB-first serial deserializer feeding an 8-entry byte FIFO with a
// registered pop output. The two halves have independent async active-high resets.
module deser_queue_top (
  input  logic       clk,
  input  logic       deserializer_rst,
  input  logic       queue_rst,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       dequeue_in,
  output logic [7:0] queue_data_out
);

  // Only the seven most recent bits need storing; the eighth arrives on data_in.
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] pending_q;
  logic       pending_vld_q;

  logic [7:0] mem [8];
  logic [2:0] wr_ptr_q;
  logic [2:0] rd_ptr_q;
  logic [3:0] count_q;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       capture;
  logic [7:0] shift_next;

  // NOTE: every output of this block is assigned first, so no latch can be inferred.
  always_comb begin
    full       = (count_q == 4'd8);
    empty      = (count_q == 4'd0);
    // Hand-off is held off while the FIFO is in reset so the pending byte survives.
    push       = pending_vld_q && !full && !queue_rst;
    pop        = dequeue_in && !empty;
    // Capture resumes on the hand-off edge, so a free-running stream loses no bits.
    capture    = write_in && (!pending_vld_q || push);
    shift_next = {shift_q, data_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge deserializer_rst) begin
    if (deserializer_rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
    end else begin
      if (push) pending_vld_q <= 1'b0;
      if (capture) begin
        shift_q <= shift_next[6:0];
        if (bit_cnt_q == 3'd7) begin
          pending_q     <= shift_next;
          pending_vld_q <= 1'b1;
          bit_cnt_q     <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end
    end
  end

  // NOTE: storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pending_q;
  end

  always_ff @(posedge clk or posedge queue_rst) begin
    if (queue_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      queue_data_out <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop) begin
        queue_data_out <= mem[rd_ptr_q];
        rd_ptr_q       <= rd_ptr_q + 3'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_queue_top.sv
// Self-checking bench for deser_queue_top: a per-cycle vector table for the basic
// byte/ordering cases plus hand-written sequences for overflow and reset corners.
module tb_deser_queue_top;

  logic       clk = 1'b0;
  logic       deserializer_rst = 1'b1;
  logic       queue_rst = 1'b1;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic [7:0] queue_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       wr;
    logic       din;
    logic       deq;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  deser_queue_top dut (
    .clk              (clk),
    .deserializer_rst (deserializer_rst),
    .queue_rst        (queue_rst),
    .data_in          (data_in),
    .write_in         (write_in),
    .dequeue_in       (dequeue_in),
    .queue_data_out   (queue_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic d, input logic q);
    @(negedge clk);
    write_in   = w;
    data_in    = d;
    dequeue_in = q;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) cyc(1'b1, b[i], 1'b0);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    cyc(1'b0, 1'b0, 1'b1);
    check(name, queue_data_out, exp);
  endtask

  function automatic void add(input logic w, input logic d, input logic q,
                              input logic c, input logic [7:0] e);
    vec_t v;
    v.wr = w; v.din = d; v.deq = q; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void add_byte(input logic [7:0] b, input logic [7:0] out_now);
    for (int i = 7; i >= 0; i--) add(1'b1, b[i], 1'b0, 1'b1, out_now);
  endfunction

  initial begin
    // Single byte B2, then pops beyond empty hold the output.
    add_byte(8'hB2, 8'h00);
    add(0, 0, 0, 1, 8'h00);
    add(0, 0, 0, 1, 8'h00);
    add(0, 0, 1, 1, 8'hB2);
    add(0, 0, 1, 1, 8'hB2);
    add(0, 0, 1, 1, 8'hB2);
    // FIFO ordering.
    add_byte(8'h01, 8'hB2);
    add_byte(8'h02, 8'hB2);
    add_byte(8'h03, 8'hB2);
    add(0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 1, 8'h01);
    add(0, 0, 1, 1, 8'h02);
    add(0, 0, 1, 1, 8'h03);
    add(0, 0, 1, 1, 8'h03);
    add(0, 0, 1, 1, 8'h03);

    // Both resets held for 20 cycles with pop and write requests active.
    dequeue_in = 1'b1;
    write_in   = 1'b1;
    data_in    = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("reset_out", queue_data_out, 8'h00);
    @(negedge clk);
    deserializer_rst = 1'b0;
    queue_rst        = 1'b0;
    write_in         = 1'b0;
    pop_chk("empty_pop_after_reset", 8'h00);

    foreach (vecs[i]) begin
      cyc(vecs[i].wr, vecs[i].din, vecs[i].deq);
      if (vecs[i].chk) check($sformatf("vec%0d", i), queue_data_out, vecs[i].exp);
    end

    // Overflow: 80 ones, 8 bytes queued, 9th pending, last 8 bits discarded.
    repeat (80) cyc(1'b1, 1'b1, 1'b0);
    check("overflow_no_pop", queue_data_out, 8'h03);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("overflow_pop%0d", i), 8'hFF);
    send_byte(8'h11);
    cyc(1'b0, 1'b0, 1'b0);
    pop_chk("overflow_ninth_ff", 8'hFF);
    pop_chk("overflow_marker", 8'h11);
    pop_chk("overflow_drained", 8'h11);

    // Deserializer reset mid-byte keeps queued bytes.
    send_byte(8'h5A);
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    write_in         = 1'b0;
    deserializer_rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    deserializer_rst = 1'b0;
    send_byte(8'hA5);
    cyc(1'b0, 1'b0, 1'b0);
    pop_chk("dreset_kept", 8'h5A);
    pop_chk("dreset_new", 8'hA5);
    pop_chk("dreset_empty", 8'hA5);

    // Queue reset empties FIFO and zeroes output asynchronously.
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    queue_rst = 1'b1;
    #1;
    check("qreset_async_out", queue_data_out, 8'h00);
    @(negedge clk);
    queue_rst = 1'b0;
    pop_chk("qreset_empty_pop", 8'h00);
    send_byte(8'h3C);
    cyc(1'b0, 1'b0, 1'b0);
    pop_chk("qreset_new_byte", 8'h3C);

    // A byte completed while the FIFO is in reset is pushed after release.
    @(negedge clk);
    queue_rst = 1'b1;
    send_byte(8'hC3);
    cyc(1'b0, 1'b0, 1'b0);
    check("qreset_hold_out", queue_data_out, 8'h00);
    @(negedge clk);
    queue_rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    pop_chk("pending_survives", 8'hC3);
    pop_chk("pending_only_one", 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
